// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding,
// used by the loader, the imem and the CPU top.
package imem_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam logic [31:0] NOP_WORD = 32'h0000_0020;

  // One extra bit so the word index can hold DEPTH itself.
  typedef logic [ADDR_W:0] widx_t;
  localparam widx_t DEPTH_IDX = widx_t'(DEPTH);

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT,
    LD_DATA,
    LD_CHECK,
    LD_FILL,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid flags the
// cycle in which the 4th byte of a word is being accepted.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shift;
  logic [1:0]  count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift <= '0;
      count <= '0;
    end else if (byte_en) begin
      shift <= {shift[15:0], byte_data};
      count <= count + 2'd1;
    end
  end

  // The completed word includes the byte currently on the bus.
  assign word       = {shift, byte_data};
  assign word_valid = byte_en && (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a counted, checksummed byte frame, writes it
// to instruction memory from address 0 and pads the rest with NOPs.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  ld_state_e   state, state_n;
  widx_t       widx;
  widx_t       n_words;
  logic [7:0]  csum;
  logic        accept;
  logic        load_start;
  logic        count_ok;
  logic        data_en;
  logic        word_valid;
  logic [31:0] word;

  assign byte_ready = (state == LD_COUNT) || (state == LD_DATA) || (state == LD_CHECK);
  assign accept     = byte_valid && byte_ready;
  assign load_start = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERROR));
  assign count_ok   = (byte_data != 8'd0) && (widx_t'(byte_data) <= DEPTH_IDX);
  assign data_en    = accept && (state == LD_DATA);

  assign busy     = (state == LD_COUNT) || (state == LD_DATA) ||
                    (state == LD_CHECK) || (state == LD_FILL);
  assign done     = (state == LD_DONE);
  assign error    = (state == LD_ERROR);
  assign cpu_hold = (state != LD_DONE);

  imem_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_en    (data_en),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (start) state_n = LD_COUNT;
      end
      LD_COUNT: begin
        if (accept) state_n = count_ok ? LD_DATA : LD_ERROR;
      end
      LD_DATA: begin
        if (word_valid && (widx + widx_t'(1) == n_words)) state_n = LD_CHECK;
      end
      LD_CHECK: begin
        if (accept) begin
          if (byte_data != csum)        state_n = LD_ERROR;
          else if (n_words == DEPTH_IDX) state_n = LD_DONE;
          else                          state_n = LD_FILL;
        end
      end
      LD_FILL: begin
        if (widx == DEPTH_IDX) state_n = LD_DONE;
      end
      default: state_n = LD_IDLE;
    endcase
  end

  // Write port is registered: the first fill write is issued on the same
  // edge that accepts a matching checksum, so fill occupies t+1..t+128-N.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      widx    <= '0;
      n_words <= '0;
      csum    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (load_start) begin
        widx    <= '0;
        n_words <= '0;
        csum    <= '0;
      end
      if ((state == LD_COUNT) && accept && count_ok) begin
        n_words <= widx_t'(byte_data);
      end
      if (data_en) begin
        csum <= csum ^ byte_data;
      end
      if (word_valid) begin
        wr_en   <= 1'b1;
        wr_addr <= widx[ADDR_W-1:0];
        wr_data <= word;
        widx    <= widx + widx_t'(1);
      end
      if (((state == LD_CHECK) && accept && (byte_data == csum) && (n_words != DEPTH_IDX)) ||
          ((state == LD_FILL) && (widx != DEPTH_IDX))) begin
        wr_en   <= 1'b1;
        wr_addr <= widx[ADDR_W-1:0];
        wr_data <= NOP_WORD;
        widx    <= widx + widx_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as
// frames are sent and matched against the write port as it fires.
module tb_imem_loader;
  import imem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb[$];
  wr_t         mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] words[128];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        chk("write", {wr_addr, wr_data}, {mon_e.addr, mon_e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int gap;
    gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        tick();
        byte_valid = 1'b0;
        return;
      end
      tick();
    end
    byte_valid = 1'b0;
    vectors++;
    miscompares++;
    $error("FAIL byte_timeout: observed byte_ready low for 200 cycles expected 1");
  endtask

  task automatic run_load(input logic [7:0] count, input int n, input bit bad_chk,
                          input int gapmax, input bit inject);
    logic [7:0] b;
    logic [7:0] csum;
    int         k;
    wr_t        e;
    start_pulse();
    send_byte(count, gapmax);
    if (count == 8'd0 || count > 8'd128) begin
      chk("count_error", error, 1'b1);
      chk("count_hold", cpu_hold, 1'b1);
      chk("count_ready", byte_ready, 1'b0);
      repeat (3) tick();
      chk("count_nowrite", sb.size(), 0);
      return;
    end
    csum = 8'h00;
    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < 4; j++) begin
        b    = words[w][31 - 8*j -: 8];
        csum = csum ^ b;
        if (j == 3) begin
          e.addr = ADDR_W'(w);
          e.data = words[w];
          sb.push_back(e);
        end
        if (inject && w == 0 && j == 2) start_pulse();
        send_byte(b, gapmax);
      end
    end
    if (bad_chk) begin
      send_byte(csum ^ 8'h03, gapmax);
      chk("chk_error", error, 1'b1);
      chk("chk_hold", cpu_hold, 1'b1);
      chk("chk_busy", busy, 1'b0);
      repeat (5) tick();
      chk("chk_nofill", sb.size(), 0);
      return;
    end
    for (int a = n; a < 128; a++) begin
      e.addr = ADDR_W'(a);
      e.data = NOP_WORD;
      sb.push_back(e);
    end
    send_byte(csum, gapmax);
    k = 1;
    for (int i = 0; i < 300; i++) begin
      start = inject && (k == 3);
      @(negedge clk);
      if (done === 1'b1) break;
      tick();
      k++;
    end
    start = 1'b0;
    chk("done_latency", k, (n == 128) ? 1 : 129 - n);
    chk("done_flag", done, 1'b1);
    chk("done_error", error, 1'b0);
    chk("done_hold", cpu_hold, 1'b0);
    chk("done_busy", busy, 1'b0);
    chk("done_sb_empty", sb.size(), 0);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_hold", cpu_hold, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_ready", byte_ready, 1'b0);

    words[0] = 32'h8C10_0000;
    words[1] = 32'h8C11_0004;
    run_load(8'd2, 2, 1'b0, 0, 1'b0);

    run_load(8'd2, 2, 1'b1, 0, 1'b0);
    run_load(8'd2, 2, 1'b0, 0, 1'b0);

    run_load(8'h00, 0, 1'b0, 0, 1'b0);
    run_load(8'h81, 0, 1'b0, 0, 1'b0);

    for (int w = 0; w < 128; w++) words[w] = $urandom;
    run_load(8'd128, 128, 1'b0, 2, 1'b0);

    words[0] = 32'h8C10_0000;
    words[1] = 32'h8C11_0004;
    start_pulse();
    send_byte(8'd2, 0);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        mon_e.addr = '0;
        mon_e.data = words[0];
        sb.push_back(mon_e);
      end
      send_byte(words[0][31 - 8*j -: 8], 0);
    end
    send_byte(words[1][31:24], 0);
    send_byte(words[1][23:16], 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_wr_en", wr_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hold", cpu_hold, 1'b1);
    chk("midrst_ready", byte_ready, 1'b0);
    chk("midrst_sb_empty", sb.size(), 0);
    sb.delete();

    run_load(8'd2, 2, 1'b0, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
